// File: rtl/tick_scheduler.sv
// Prescaled base tick driving four independently programmable tick channels.
// Define TICK_SCHED_WAVE_EN to add the per-channel ch_wave square outputs.
module tick_scheduler #(
  parameter int CLK_HZ  = 100000000,
  parameter int BASE_HZ = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [1:0]  cfg_ch,
  input  logic [15:0] cfg_period,
  output logic        base_tick,
  output logic [3:0]  ch_tick,
`ifdef TICK_SCHED_WAVE_EN
  output logic [3:0]  ch_active,
  output logic [3:0]  ch_wave
`else
  output logic [3:0]  ch_active
`endif
);

  localparam int PRESCALE = CLK_HZ / BASE_HZ;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre;
  logic [15:0]   per [4];
  logic [15:0]   cnt [4];
  logic [15:0]   nxt [4];
  logic [3:0]    pend;
  logic [3:0]    term;
  logic [3:0]    apply;
  logic [3:0]    xfer;

  assign base_tick = (pre == PRE_LAST);
  assign cfg_ready = ~pend[cfg_ch];

  // Idle channels pick up a pending period at once; live ones wait for wrap.
  always_comb begin
    term  = '0;
    apply = '0;
    xfer  = '0;
    for (int i = 0; i < 4; i++) begin
      term[i]  = base_tick && (per[i] != 16'd0)
              && (cnt[i] == per[i] - 16'd1);
      apply[i] = pend[i] && (term[i] || (per[i] == 16'd0));
      xfer[i]  = cfg_valid && cfg_ready && (cfg_ch == 2'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre       <= '0;
      pend      <= '0;
      ch_tick   <= '0;
      ch_active <= '0;
      for (int i = 0; i < 4; i++) begin
        per[i] <= '0;
        cnt[i] <= '0;
        nxt[i] <= '0;
      end
    end else begin
      pre     <= base_tick ? '0 : pre + PW'(1);
      ch_tick <= term;
      for (int i = 0; i < 4; i++) begin
        if (apply[i]) begin
          per[i]       <= nxt[i];
          cnt[i]       <= '0;
          pend[i]      <= 1'b0;
          ch_active[i] <= |nxt[i];
        end else if (term[i]) begin
          cnt[i] <= '0;
        end else if (base_tick && (per[i] != 16'd0)) begin
          cnt[i] <= cnt[i] + 16'd1;
        end
        if (xfer[i]) begin
          nxt[i]  <= cfg_period;
          pend[i] <= 1'b1;
        end
      end
    end
  end

`ifdef TICK_SCHED_WAVE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_wave <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (apply[i] && (nxt[i] == 16'd0)) begin
          ch_wave[i] <= 1'b0;
        end else if (term[i]) begin
          ch_wave[i] <= ~ch_wave[i];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler at CLK_HZ=100, BASE_HZ=10.
// Reference model counts base ticks since each period was applied.
module tb_tick_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_ch = '0;
  logic [15:0] cfg_period = '0;
  logic        base_tick;
  logic [3:0]  ch_tick;
  logic [3:0]  ch_active;

  int tests = 0;
  int fails = 0;

`ifdef TICK_SCHED_WAVE_EN
  localparam int OW = 14;
  logic [3:0] ch_wave;
`else
  localparam int OW = 10;
`endif

  logic [OW-1:0] obs;

  always #5 clk = ~clk;

  tick_scheduler #(
    .CLK_HZ (100),
    .BASE_HZ(10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_period(cfg_period),
    .base_tick (base_tick),
    .ch_tick   (ch_tick),
`ifdef TICK_SCHED_WAVE_EN
    .ch_active (ch_active),
    .ch_wave   (ch_wave)
`else
    .ch_active (ch_active)
`endif
  );

`ifdef TICK_SCHED_WAVE_EN
  assign obs = {ch_wave, base_tick, ch_tick, ch_active, cfg_ready};
`else
  assign obs = {base_tick, ch_tick, ch_active, cfg_ready};
`endif

  // Reference model state
  int       cyc;
  int       mp [4];
  int       mel [4];
  int       mn [4];
  bit       mf [4];
  bit [3:0] mtick;
  bit [3:0] mwave;

  task automatic model_reset();
    cyc = 0;
    mtick = '0;
    mwave = '0;
    for (int i = 0; i < 4; i++) begin
      mp[i] = 0;
      mel[i] = 0;
      mn[i] = 0;
      mf[i] = 0;
    end
  endtask

  task automatic model_step();
    bit bt;
    bit [3:0] nt;
    int xc;
    bt = (cyc % 10 == 9);
    nt = '0;
    xc = -1;
    if (cfg_valid && !mf[cfg_ch]) xc = int'(cfg_ch);
    for (int i = 0; i < 4; i++) begin
      if (bt && mp[i] != 0) begin
        mel[i]++;
        if (mel[i] % mp[i] == 0) nt[i] = 1'b1;
      end
      if (nt[i]) mwave[i] = ~mwave[i];
      if (mf[i] && (mp[i] == 0 || nt[i])) begin
        mp[i] = mn[i];
        mel[i] = 0;
        mf[i] = 0;
        if (mn[i] == 0) mwave[i] = 1'b0;
      end
      if (xc == i) begin
        mn[i] = int'(cfg_period);
        mf[i] = 1;
      end
    end
    mtick = nt;
    cyc++;
  endtask

  function automatic logic [OW-1:0] expv();
    logic [3:0] act;
    logic bt;
    for (int i = 0; i < 4; i++) act[i] = (mp[i] != 0);
    bt = (cyc % 10 == 9);
`ifdef TICK_SCHED_WAVE_EN
    return {mwave, bt, mtick, act, !mf[cfg_ch]};
`else
    return {bt, mtick, act, !mf[cfg_ch]};
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
  endtask

  task automatic send(input int ch, input int p, output bit ok);
    ok = 1'b0;
    cfg_valid = 1'b1;
    cfg_ch = 2'(ch);
    cfg_period = 16'(p);
    for (int k = 0; k < 400 && !ok; k++) begin
      ok = !mf[ch];
      tick();
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) begin
      tick();
      tests++;
      if (obs !== expv()) begin
        fails++;
        $display("FAIL reset got=%b exp=%b", obs, expv());
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    int nbt = 0;
    repeat (50) begin
      tick();
      nbt += int'(base_tick);
      tests++;
      if (obs !== expv()) begin
        fails++;
        $display("FAIL idle cyc=%0d got=%b exp=%b", cyc, obs, expv());
      end
    end
    tests++;
    if (nbt != 5) begin
      fails++;
      $display("FAIL idle_count got=%0d exp=5", nbt);
    end
  endtask

  task automatic test_single();
    bit ok;
    send(0, 3, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL single_cfg got=timeout exp=transfer");
    end
    repeat (130) begin
      tick();
      tests++;
      if (obs !== expv()) begin
        fails++;
        $display("FAIL single cyc=%0d got=%b exp=%b", cyc, obs, expv());
      end
    end
  endtask

  task automatic test_reprogram();
    bit ok;
    int k;
    send(1, 4, ok);
    repeat (15) tick();
    send(1, 2, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL reprog_cfg got=timeout exp=transfer");
    end
    cfg_valid = 1'b1;
    cfg_period = 16'd2;
    k = 0;
    while (mf[1] && k < 200) begin
      tick();
      k++;
      tests++;
      if (obs !== expv()) begin
        fails++;
        $display("FAIL reprog_pend cyc=%0d got=%b exp=%b", cyc, obs, expv());
      end
    end
    cfg_valid = 1'b0;
    tests++;
    if (k >= 200) begin
      fails++;
      $display("FAIL reprog_wait got=timeout exp=apply");
    end
    repeat (70) begin
      tick();
      tests++;
      if (obs !== expv()) begin
        fails++;
        $display("FAIL reprog cyc=%0d got=%b exp=%b", cyc, obs, expv());
      end
    end
  endtask

  task automatic test_disable();
    bit ok;
    int k;
    send(0, 0, ok);
    cfg_valid = 1'b1;
    cfg_period = 16'd5;
    k = 0;
    while (mf[0] && k < 200) begin
      tick();
      k++;
      tests++;
      if (obs !== expv()) begin
        fails++;
        $display("FAIL disable_stall cyc=%0d got=%b exp=%b", cyc, obs, expv());
      end
    end
    tests++;
    if (k >= 200 || ch_active[0] !== 1'b0) begin
      fails++;
      $display("FAIL disable_drop got=%b exp=0", ch_active[0]);
    end
    repeat (80) begin
      tick();
      if (cfg_valid && !mf[0]) cfg_valid = 1'b0;
      tests++;
      if (obs !== expv()) begin
        fails++;
        $display("FAIL disable cyc=%0d got=%b exp=%b", cyc, obs, expv());
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_multi();
    bit ok;
    int both = 0;
    send(2, 1, ok);
    send(3, 2, ok);
    repeat (60) begin
      tick();
      if (ch_tick[3] && ch_tick[2]) both++;
      tests++;
      if (obs !== expv()) begin
        fails++;
        $display("FAIL multi cyc=%0d got=%b exp=%b", cyc, obs, expv());
      end
    end
    tests++;
    if (both < 2) begin
      fails++;
      $display("FAIL multi_coincide got=%0d exp>=2", both);
    end
  endtask

  task automatic test_random();
    repeat (3000) begin
      cfg_valid = ($urandom % 4 == 0);
      cfg_ch = 2'($urandom % 4);
      cfg_period = ($urandom % 8 == 0) ? 16'd0 : 16'($urandom_range(1, 5));
      tick();
      tests++;
      if (obs !== expv()) begin
        fails++;
        $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs, expv());
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    send(1, 7, ok);
    cfg_ch = 2'd1;
    repeat (4) tick();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    tests++;
    if (obs !== expv()) begin
      fails++;
      $display("FAIL reset_async got=%b exp=%b", obs, expv());
    end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (60) begin
      tick();
      tests++;
      if (obs !== expv()) begin
        fails++;
        $display("FAIL reset_mid cyc=%0d got=%b exp=%b", cyc, obs, expv());
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_reprogram();
    test_disable();
    test_multi();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
